// File: rtl/conv1_window_gen_if.sv
// Pixel-stream in / 3x3 window out bus for conv1_window_gen.
// data_out is row-major: [0] is the oldest (r-2,c-2), [8] the newest pixel (r,c).
interface conv1_window_gen_if #(
  parameter int DATA_W = 32
);
  logic                   pixel_valid;
  logic [DATA_W-1:0]      pixel_in;
  logic [0:8][DATA_W-1:0] data_out;
  logic                   valid_out;
  logic                   frame_done;

  modport master (
    output pixel_valid, pixel_in,
    input  data_out, valid_out, frame_done
  );

  modport slave (
    input  pixel_valid, pixel_in,
    output data_out, valid_out, frame_done
  );
endinterface

// File: rtl/conv1_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers feed the right column
// of a 3x3 register window; one window per interior pixel, stride 1, no padding.

// One row of the window: a 3-tap shift register that moves left on each accept.
module conv1_win_row #(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic [DATA_W-1:0]      i_din,
  output logic [0:2][DATA_W-1:0] o_taps
);
  logic [0:2][DATA_W-1:0] r_taps;

  always_ff @(posedge clk) begin
    if (!rst_n)    r_taps <= '0;
    else if (i_en) r_taps <= {r_taps[1], r_taps[2], i_din};
  end

  assign o_taps = r_taps;
endmodule

module conv1_window_gen #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic clk,
  input  logic rst_n,
  conv1_window_gen_if.slave bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [DATA_W-1:0] r_lb0 [IMG_W];
  logic [DATA_W-1:0] r_lb1 [IMG_W];

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_valid;
  logic          r_frame_done;

  logic                   w_accept;
  logic                   w_col_last;
  logic                   w_row_last;
  logic                   w_win_pos;
  logic [DATA_W-1:0]      w_lb0_rd;
  logic [DATA_W-1:0]      w_lb1_rd;
  logic [0:2][DATA_W-1:0] w_col_d;
  logic [0:2][0:2][DATA_W-1:0] w_taps;
  logic [0:8][DATA_W-1:0] w_win;

  assign w_accept   = bus.pixel_valid;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_win_pos  = (r_row >= ROW_TWO) && (r_col >= COL_TWO);

  // Reads see the old contents, so the incoming pixel never reaches its own column.
  assign w_lb0_rd = r_lb0[r_col];
  assign w_lb1_rd = r_lb1[r_col];
  assign w_col_d  = {w_lb1_rd, w_lb0_rd, bus.pixel_in};

  // Line buffers carry no reset; stale data is masked by the row>=2 gate.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= w_lb0_rd;
      r_lb0[r_col] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid      <= w_accept && w_win_pos;
      r_frame_done <= w_accept && w_row_last && w_col_last;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    conv1_win_row #(.DATA_W(DATA_W)) u_row (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_accept),
      .i_din  (w_col_d[gi]),
      .o_taps (w_taps[gi])
    );
  end

  always_comb begin
    w_win = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w_win[3*i+j] = w_taps[i][j];
  end

  assign bus.data_out   = w_win;
  assign bus.valid_out  = r_valid;
  assign bus.frame_done = r_frame_done;
endmodule
